// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin arbiter in front of a single ALU. A granted
//   request's payload is registered onto the alu_* outputs and held while
//   the ALU works on it. The arbiter then reports back to the requester with
//   a done pulse, or with an err pulse if the ALU stays silent for TIMEOUT
//   cycles.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   reqN_valid                   requester N has an operation (level)
//   reqN_op_code/a/b             opcode and operands of requester N
//   reqN_reg_out/mem_out         destination selects of requester N
//   reqN_reg_addr/mem_addr       destination addresses of requester N
//   reqN_ack/done/err            one-cycle pulses back to requester N
//   alu_*                        registered payload to the ALU
//   alu_inputs_valid             qualifies the ALU payload
//   alu_pc_jump                  constant 0
//   alu_input_ack, alu_done      one-cycle pulses from the ALU
//   busy                         arbiter is not idle
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op_code,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_reg_out,
  input  logic        req0_mem_out,
  input  logic [4:0]  req0_reg_addr,
  input  logic [31:0] req0_mem_addr,
  output logic        req0_ack,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op_code,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_reg_out,
  input  logic        req1_mem_out,
  input  logic [4:0]  req1_reg_addr,
  input  logic [31:0] req1_mem_addr,
  output logic        req1_ack,
  output logic        req1_done,
  output logic        req1_err,
  output logic [3:0]  alu_op_code,
  output logic [31:0] alu_input_A,
  output logic [31:0] alu_input_B,
  output logic        alu_reg_out,
  output logic        alu_mem_out,
  output logic [4:0]  alu_reg_addr,
  output logic [31:0] alu_mem_addr,
  output logic        alu_inputs_valid,
  output logic        alu_pc_jump,
  input  logic        alu_input_ack,
  input  logic        alu_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  // The counter holds 0 during the first ISSUE cycle. The edge that would
  // bring it to TIMEOUT is the abort edge, so the compare is against TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       ptr;    // requester with priority on the next tie
  logic       grant;  // requester owning the in-flight operation
  logic [7:0] cnt;
  logic       sel;

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ptr;
    else if (req1_valid)          sel = 1'b1;
  end

  assign alu_pc_jump = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      ptr              <= 1'b0;
      grant            <= 1'b0;
      cnt              <= '0;
      busy             <= 1'b0;
      alu_inputs_valid <= 1'b0;
      alu_op_code      <= '0;
      alu_input_A      <= '0;
      alu_input_B      <= '0;
      alu_reg_out      <= 1'b0;
      alu_mem_out      <= 1'b0;
      alu_reg_addr     <= '0;
      alu_mem_addr     <= '0;
      req0_ack         <= 1'b0;
      req1_ack         <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_err         <= 1'b0;
      req1_err         <= 1'b0;
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            state            <= ISSUE;
            busy             <= 1'b1;
            grant            <= sel;
            ptr              <= ~sel;
            cnt              <= '0;
            alu_inputs_valid <= 1'b1;
            alu_op_code      <= sel ? req1_op_code  : req0_op_code;
            alu_input_A      <= sel ? req1_a        : req0_a;
            alu_input_B      <= sel ? req1_b        : req0_b;
            alu_reg_out      <= sel ? req1_reg_out  : req0_reg_out;
            alu_mem_out      <= sel ? req1_mem_out  : req0_mem_out;
            alu_reg_addr     <= sel ? req1_reg_addr : req0_reg_addr;
            alu_mem_addr     <= sel ? req1_mem_addr : req0_mem_addr;
            req0_ack         <= ~sel;
            req1_ack         <= sel;
          end
        end
        ISSUE, WAIT: begin
          cnt <= cnt + 8'd1;
          if (alu_done) begin
            state            <= RELEASE;
            alu_inputs_valid <= 1'b0;
            req0_done        <= ~grant;
            req1_done        <= grant;
          end else if (cnt == CNT_LAST) begin
            state            <= RELEASE;
            alu_inputs_valid <= 1'b0;
            req0_err         <= ~grant;
            req1_err         <= grant;
          end else if (state == ISSUE && alu_input_ack) begin
            state <= WAIT;
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Expected transactions go into a scoreboard
// queue when a request is presented. They are compared at grant time for
// requester and payload, and at completion for outcome and valid duration.
module tb_alu_arbiter;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op_code, req1_op_code;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_reg_out, req0_mem_out, req1_reg_out, req1_mem_out;
  logic [4:0]  req0_reg_addr, req1_reg_addr;
  logic [31:0] req0_mem_addr, req1_mem_addr;
  logic        req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
  logic [3:0]  alu_op_code;
  logic [31:0] alu_input_A, alu_input_B, alu_mem_addr;
  logic        alu_reg_out, alu_mem_out, alu_inputs_valid, alu_pc_jump;
  logic [4:0]  alu_reg_addr;
  logic        alu_input_ack, alu_done, busy;

  alu_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op_code(req0_op_code), .req0_a(req0_a),
    .req0_b(req0_b), .req0_reg_out(req0_reg_out), .req0_mem_out(req0_mem_out),
    .req0_reg_addr(req0_reg_addr), .req0_mem_addr(req0_mem_addr),
    .req0_ack(req0_ack), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_op_code(req1_op_code), .req1_a(req1_a),
    .req1_b(req1_b), .req1_reg_out(req1_reg_out), .req1_mem_out(req1_mem_out),
    .req1_reg_addr(req1_reg_addr), .req1_mem_addr(req1_mem_addr),
    .req1_ack(req1_ack), .req1_done(req1_done), .req1_err(req1_err),
    .alu_op_code(alu_op_code), .alu_input_A(alu_input_A),
    .alu_input_B(alu_input_B), .alu_reg_out(alu_reg_out),
    .alu_mem_out(alu_mem_out), .alu_reg_addr(alu_reg_addr),
    .alu_mem_addr(alu_mem_addr), .alu_inputs_valid(alu_inputs_valid),
    .alu_pc_jump(alu_pc_jump), .alu_input_ack(alu_input_ack),
    .alu_done(alu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned req;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        ro, mo;
    logic [4:0]  ra;
    logic [31:0] ma;
    logic        err;
    int unsigned vcyc;
  } txn_t;

  txn_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(int unsigned req, logic [3:0] op, logic [31:0] a,
                              logic [31:0] b, logic ro, logic mo, logic [4:0] ra,
                              logic [31:0] ma, logic err, int unsigned vcyc);
    txn_t t;
    t.req = req; t.op = op; t.a = a; t.b = b; t.ro = ro; t.mo = mo;
    t.ra = ra; t.ma = ma; t.err = err; t.vcyc = vcyc;
    return t;
  endfunction

  task automatic present(txn_t t);
    if (t.req == 0) begin
      req0_op_code = t.op; req0_a = t.a; req0_b = t.b; req0_reg_out = t.ro;
      req0_mem_out = t.mo; req0_reg_addr = t.ra; req0_mem_addr = t.ma;
      req0_valid = 1'b1;
    end else begin
      req1_op_code = t.op; req1_a = t.a; req1_b = t.b; req1_reg_out = t.ro;
      req1_mem_out = t.mo; req1_reg_addr = t.ra; req1_mem_addr = t.ma;
      req1_valid = 1'b1;
    end
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_ctrl"}, {21'd0, req0_ack, req1_ack, req0_done, req1_done,
        req0_err, req1_err, busy, alu_inputs_valid, alu_reg_out, alu_mem_out,
        alu_pc_jump}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_quiet("rst");
    chk("rst_A", alu_input_A, 32'd0);
    chk("rst_B", alu_input_B, 32'd0);
    chk("rst_mem_addr", alu_mem_addr, 32'd0);
    chk("rst_op_regaddr", {23'd0, alu_op_code, alu_reg_addr}, 32'd0);
  endtask

  // Wait (bounded) for an ack and compare against the scoreboard head.
  task automatic expect_grant(bit drop);
    txn_t t;
    bit   seen = 0;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    t = sb[0];
    for (int i = 0; i < 20; i++) begin
      step();
      if (req0_ack || req1_ack) begin seen = 1; break; end
    end
    chk("grant_seen", 32'(seen), 32'd1);
    chk("grant_req", 32'(req1_ack), 32'(t.req));
    chk("grant_onehot", 32'(req0_ack ^ req1_ack), 32'd1);
    chk("grant_ivalid", 32'(alu_inputs_valid), 32'd1);
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_op", 32'(alu_op_code), 32'(t.op));
    chk("grant_A", alu_input_A, t.a);
    chk("grant_B", alu_input_B, t.b);
    chk("grant_dst", {30'd0, alu_reg_out, alu_mem_out}, {30'd0, t.ro, t.mo});
    chk("grant_reg_addr", 32'(alu_reg_addr), 32'(t.ra));
    chk("grant_mem_addr", alu_mem_addr, t.ma);
    chk("pc_jump", 32'(alu_pc_jump), 32'd0);
    if (drop) begin
      if (t.req == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  // ALU behaviour: 0 ack then done, 1 ack+done together, 2 silent,
  // 3 done on the last cycle before the abort.
  task automatic finish_op(int unsigned mode);
    txn_t t;
    int unsigned vcnt = 1;
    bit seen = 0;
    logic d, e, od;
    t = sb[0];
    for (int unsigned c = 0; c < 40; c++) begin
      alu_input_ack = (mode <= 1 && c == 0);
      alu_done = (mode == 0 && c == 1) || (mode == 1 && c == 0) ||
                 (mode == 3 && c == TMO - 1);
      step();
      alu_input_ack = 1'b0; alu_done = 1'b0;
      if (req0_done || req1_done || req0_err || req1_err) begin seen = 1; break; end
      if (alu_inputs_valid) vcnt++;
    end
    d  = (t.req == 0) ? req0_done : req1_done;
    e  = (t.req == 0) ? req0_err  : req1_err;
    od = (t.req == 0) ? (req1_done | req1_err) : (req0_done | req0_err);
    chk("end_seen", 32'(seen), 32'd1);
    chk("valid_cycles", vcnt, t.vcyc);
    chk("done_pulse", 32'(d), 32'(!t.err));
    chk("err_pulse", 32'(e), 32'(t.err));
    chk("other_quiet", 32'(od), 32'd0);
    chk("rel_ivalid", 32'(alu_inputs_valid), 32'd0);
    chk("rel_busy", 32'(busy), 32'd1);
    step();
    chk("pulses_clear", {26'd0, req0_ack, req1_ack, req0_done, req1_done,
        req0_err, req1_err}, 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    void'(sb.pop_front());
  endtask

  initial begin
    txn_t t0, t1;
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    alu_input_ack = 1'b0; alu_done = 1'b0;
    present(mk(0, 4'd0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 0)); req0_valid = 1'b0;
    present(mk(1, 4'd0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 0)); req1_valid = 1'b0;
    step(); step();
    check_reset_outputs();
    reset_n = 1'b1;

    // Spurious ALU pulses in IDLE are ignored.
    alu_done = 1'b1; alu_input_ack = 1'b1;
    step();
    alu_done = 1'b0; alu_input_ack = 1'b0;
    check_quiet("spurious1");
    step();
    check_quiet("spurious2");

    // Single ADD from req0.
    t0 = mk(0, 4'b0000, 32'd5, 32'd7, 1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 2);
    present(t0); sb.push_back(t0);
    expect_grant(1); finish_op(0);

    // ack and done together skip WAIT.
    t1 = mk(1, 4'b0001, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 5'd17,
            32'hA5A5_0004, 1'b0, 1);
    present(t1); sb.push_back(t1);
    expect_grant(1); finish_op(1);

    // Silent ALU -> timeout, then a normal request.
    t0 = mk(0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 5'd31,
            32'hFFFF_FFFC, 1'b1, TMO);
    present(t0); sb.push_back(t0);
    expect_grant(1); finish_op(2);
    t1 = mk(1, 4'b1010, 32'd9, 32'd4, 1'b1, 1'b0, 5'd1, 32'h10, 1'b0, 2);
    present(t1); sb.push_back(t1);
    expect_grant(1); finish_op(0);

    // done on the same edge the counter would expire: done wins.
    t0 = mk(0, 4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 5'd8,
            32'h44, 1'b0, TMO);
    present(t0); sb.push_back(t0);
    expect_grant(1); finish_op(3);

    // After reset both requesters continuously valid: 0, 1, 0.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    t0 = mk(0, 4'b0011, 32'd100, 32'd200, 1'b1, 1'b0, 5'd2, 32'h0, 1'b0, 2);
    t1 = mk(1, 4'b0100, 32'd300, 32'd400, 1'b0, 1'b1, 5'd9, 32'h80, 1'b0, 2);
    present(t0); present(t1);
    sb.push_back(t0); sb.push_back(t1); sb.push_back(t0);
    expect_grant(0); finish_op(0);
    expect_grant(0); finish_op(0);
    expect_grant(0); finish_op(0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during WAIT with req1 granted aborts silently; req1 re-granted.
    t1 = mk(1, 4'b0110, 32'h55, 32'hAA, 1'b1, 1'b1, 5'd12, 32'hC0, 1'b0, 2);
    present(t1); sb.push_back(t1);
    expect_grant(0);
    alu_input_ack = 1'b1; step(); alu_input_ack = 1'b0;
    chk("wait_ivalid", 32'(alu_inputs_valid), 32'd1);
    reset_n = 1'b0; step();
    check_reset_outputs();
    reset_n = 1'b1;
    expect_grant(1); finish_op(0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
